// File: rtl/key_scan_if.sv
// ---------------------------------------------------------------------------
// key_scan_if
// Signal bundle between the keypad scanner and its surroundings.
//
//   row_out   [3:0]  active-low row drive towards the keypad
//   col_in    [3:0]  active-low column sense from the keypad (pulled up)
//   key_code  [3:0]  last accepted key, {row[1:0], col[1:0]}
//   key_valid        one-cycle pulse per accepted key event
//   key_held         high while an accepted key is still down
//
// Modports:
//   master  - the scanner (drives rows and key outputs, senses columns)
//   slave   - keypad/consumer side (drives columns, observes everything else)
// ---------------------------------------------------------------------------
interface key_scan_if;
    logic [3:0] row_out;
    logic [3:0] col_in;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output row_out,
        output key_code,
        output key_valid,
        output key_held,
        input  col_in
    );

    modport slave (
        input  row_out,
        input  key_code,
        input  key_valid,
        input  key_held,
        output col_in
    );
endinterface

// File: rtl/key_scan.sv
// ---------------------------------------------------------------------------
// key_scan
// 4x4 matrix keypad scanner with press/release debouncing.
//
// Rows are driven low one at a time; each row is held for SCAN_HOLD cycles
// and its columns are sampled on the last cycle of the hold. A low column
// freezes the scan on that row and the key must stay down for DEBOUNCE
// consecutive cycles before it is reported. Release is debounced the same
// way before scanning resumes on the following row.
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-high reset
//   kp        key_scan_if.master: row_out, col_in, key_code, key_valid,
//             key_held (all outputs registered)
//
// Parameters:
//   DEBOUNCE   stable cycles needed to accept a press or a release
//   SCAN_HOLD  cycles each row is driven before its columns are sampled
//   REPEAT     auto-repeat period in cycles (auto-repeat builds only)
//
// Build option:
//   KEY_SCAN_AUTOREPEAT_EN  when defined, key_valid re-pulses every REPEAT
//                           cycles while a key stays held. When undefined,
//                           exactly one key_valid pulse is produced per press.
// ---------------------------------------------------------------------------
module key_scan #(
    parameter int DEBOUNCE  = 20,
    parameter int SCAN_HOLD = 2,
    parameter int REPEAT    = 250
) (
    input  logic          clk,
    input  logic          rst,
    key_scan_if.master    kp
);

    // Zero values would make the terminal-count compares below meaningless.
    if (DEBOUNCE < 1 || SCAN_HOLD < 1 || REPEAT < 1) begin : g_bad_params
        $error("key_scan: DEBOUNCE, SCAN_HOLD and REPEAT must all be >= 1");
    end

    localparam int DEB_W  = $clog2(DEBOUNCE) + 1;
    localparam int HOLD_W = $clog2(SCAN_HOLD) + 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DEB,
        HELD,
        REL_DEB
    } state_e;

    state_e            state_q,    state_d;
    logic [1:0]        row_idx_q,  row_idx_d;
    logic [1:0]        col_idx_q,  col_idx_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
    logic [3:0]        row_out_q,  row_out_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q,  key_held_d;

    logic              accept;
    logic              release_done;
    logic              col_sel;

`ifdef KEY_SCAN_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT) + 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);

    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              repeat_fire;
`endif

    // Column belonging to the key being debounced or held; the other
    // columns are deliberately ignored once a key has been picked.
    assign col_sel = kp.col_in[col_idx_q];

    // When several keys in the row are down, the lowest column index wins.
    function automatic logic [1:0] first_low(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // State register and all datapath/output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            hold_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            row_out_q   <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEY_SCAN_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            hold_cnt_q  <= hold_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            row_out_q   <= row_out_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEY_SCAN_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    // Next-state and counter logic. Counters only ever compare against their
    // terminal value and are cleared on every state change, so they never
    // wrap while a state is active. The sample that causes a state change is
    // not counted: debouncing starts from zero in the new state.
    always_comb begin
        state_d      = state_q;
        row_idx_d    = row_idx_q;
        col_idx_d    = col_idx_q;
        hold_cnt_d   = hold_cnt_q;
        deb_cnt_d    = deb_cnt_q;
        accept       = 1'b0;
        release_done = 1'b0;
`ifdef KEY_SCAN_AUTOREPEAT_EN
        rep_cnt_d    = rep_cnt_q;
        repeat_fire  = 1'b0;
`endif

        case (state_q)
            SCAN: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    if (&kp.col_in) begin
                        row_idx_d = row_idx_q + 2'd1;
                    end else begin
                        col_idx_d = first_low(kp.col_in);
                        deb_cnt_d = '0;
                        state_d   = PRESS_DEB;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            PRESS_DEB: begin
                if (col_sel) begin
                    // Glitch: drop it and move on as if the row were idle.
                    state_d    = SCAN;
                    row_idx_d  = row_idx_q + 2'd1;
                    hold_cnt_d = '0;
                    deb_cnt_d  = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    accept    = 1'b1;
                    deb_cnt_d = '0;
                    state_d   = HELD;
`ifdef KEY_SCAN_AUTOREPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end

            HELD: begin
                if (col_sel) begin
                    deb_cnt_d = '0;
                    state_d   = REL_DEB;
`ifdef KEY_SCAN_AUTOREPEAT_EN
                    rep_cnt_d = '0;
`endif
                end
`ifdef KEY_SCAN_AUTOREPEAT_EN
                else if (rep_cnt_q == REP_LAST) begin
                    repeat_fire = 1'b1;
                    rep_cnt_d   = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
`endif
            end

            REL_DEB: begin
                if (!col_sel) begin
                    // Release bounce: the key is still considered down.
                    deb_cnt_d = '0;
                    state_d   = HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    release_done = 1'b1;
                    deb_cnt_d    = '0;
                    row_idx_d    = row_idx_q + 2'd1;
                    hold_cnt_d   = '0;
                    state_d      = SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // Output logic, registered through the *_q flops above. row_out is
    // decoded from the next row index so it changes on the same edge as
    // row_idx.
    always_comb begin
        row_out_d  = ~(4'b0001 << row_idx_d);
        key_code_d = key_code_q;
        key_held_d = key_held_q;

        if (accept) begin
            key_code_d = {row_idx_q, col_idx_q};
            key_held_d = 1'b1;
        end else if (release_done) begin
            key_held_d = 1'b0;
        end

`ifdef KEY_SCAN_AUTOREPEAT_EN
        key_valid_d = accept | repeat_fire;
`else
        key_valid_d = accept;
`endif
    end

    assign kp.row_out   = row_out_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_key_scan.sv
// ---------------------------------------------------------------------------
// tb_key_scan
// Self-checking bench for key_scan. A physical 4x4 keypad is emulated from a
// 16-bit "keys down" mask and the row drive. Expected outputs are derived
// from scan timing arithmetic: idle rows advance every SH cycles, a key is
// picked up on the first sample of its row, reported D cycles later, and
// released D cycles after the final release edge is seen.
// Compile with +define+KEY_SCAN_AUTOREPEAT_EN to also cover auto-repeat.
// ---------------------------------------------------------------------------
module tb_key_scan;

    localparam int D  = 20;
    localparam int SH = 2;
    localparam int R  = 250;

    logic        clk;
    logic        rst;
    logic [15:0] pressed;
    logic [3:0]  col_n;

    int n_vec;
    int n_err;
    int cyc;
    int base_cyc;
    int base_row;
    logic [3:0] exp_code;

    int bhi[3];
    int blo[3];

    key_scan_if kif ();

    key_scan #(
        .DEBOUNCE  (D),
        .SCAN_HOLD (SH),
        .REPEAT    (R)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a down key connects its row line to its column line.
    always_comb begin
        col_n = 4'b1111;
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                if (pressed[rr*4+cc] && !kif.row_out[rr]) col_n[cc] = 1'b0;
            end
        end
    end
    assign kif.col_in = col_n;

    task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check_cycle(input int row, input bit v, input bit h, input logic [3:0] code);
        logic [3:0] oh;
        oh = 4'b0001 << row;
        checkOutput("row_out",   {4'b0, kif.row_out},   {4'b0, ~oh});
        checkOutput("key_valid", {7'b0, kif.key_valid}, {7'b0, v});
        checkOutput("key_held",  {7'b0, kif.key_held},  {7'b0, h});
        checkOutput("key_code",  {4'b0, kif.key_code},  {4'b0, code});
    endtask

    function automatic int scan_row(input int n);
        return (base_row + (n - base_cyc) / SH) % 4;
    endfunction

    // First sampling edge of row r that sees a key put down in cycle tp.
    function automatic int next_sample(input int r, input int tp);
        int e;
        for (int k = 0; k < 64; k++) begin
            e = base_cyc + (k + 1) * SH;
            if ((base_row + k) % 4 == r && e - 1 >= tp) return e;
        end
        return -1;
    endfunction

    function automatic bit key_down(input int n, input int tp, input int t_rel,
                                    input bit accepted, input int nb);
        int t;
        if (n < tp) return 1'b0;
        if (n < t_rel) return 1'b1;
        if (!accepted) return 1'b0;
        t = t_rel;
        for (int i = 0; i < nb; i++) begin
            if (n < t + bhi[i]) return 1'b0;
            t += bhi[i];
            if (n < t + blo[i]) return 1'b1;
            t += blo[i];
        end
        return 1'b0;
    endfunction

    task automatic idle(input int ncyc);
        pressed = 16'h0;
        for (int i = 0; i < ncyc; i++) begin
            check_cycle(scan_row(cyc), 1'b0, 1'b0, exp_code);
            step();
        end
    endtask

    // One key event in row r: key goes down 'lead' cycles from now, stays
    // down until hold_after cycles past pickup, then releases with nb
    // bounces described by bhi/blo, followed by 'tail' idle cycles.
    task automatic applyStimulus(input int r, input logic [3:0] cols, input int lead,
                                 input int hold_after, input int nb, input int tail);
        int tp, e, t_rel, acc, clr, new_base, last, n, row, t;
        bit accepted, v, h;
        logic [15:0] pmask;
        logic [3:0]  code_new, code;
        logic [1:0]  lc;
`ifdef KEY_SCAN_AUTOREPEAT_EN
        int hs[4];
        int he[4];
        int nh;
`endif
        lc = 2'd0;
        for (int c = 3; c >= 0; c--) if (cols[c]) lc = 2'(c);
        code_new = {2'(r), lc};
        pmask    = 16'(cols) << (4 * r);
        tp       = cyc + lead;
        e        = next_sample(r, tp);
        t_rel    = e + hold_after;
        acc      = e + D;
        accepted = (hold_after >= D);
        t = t_rel;
`ifdef KEY_SCAN_AUTOREPEAT_EN
        hs[0] = acc;
        he[0] = t_rel;
        nh    = 1;
`endif
        if (accepted) begin
            for (int i = 0; i < nb; i++) begin
                t += bhi[i];
`ifdef KEY_SCAN_AUTOREPEAT_EN
                hs[nh] = t + 1;
                he[nh] = t + blo[i];
                nh++;
`endif
                t += blo[i];
            end
        end
        clr      = t + 1 + D;
        new_base = accepted ? clr : t_rel + 1;
        last     = new_base + tail;

        while (cyc < last) begin
            n = cyc;
            pressed = key_down(n, tp, t_rel, accepted, nb) ? pmask : 16'h0;
            if (n < e)             row = scan_row(n);
            else if (n < new_base) row = r;
            else                   row = (r + 1 + (n - new_base) / SH) % 4;
            v = accepted && (n == acc);
`ifdef KEY_SCAN_AUTOREPEAT_EN
            if (accepted) begin
                for (int j = 0; j < nh; j++) begin
                    if (n > hs[j] && n <= he[j] && (n - hs[j]) % R == 0) v = 1'b1;
                end
            end
`endif
            h    = accepted && n >= acc && n < clr;
            code = (accepted && n >= acc) ? code_new : exp_code;
            check_cycle(row, v, h, code);
            step();
        end

        pressed = 16'h0;
        if (accepted) exp_code = code_new;
        base_cyc = new_base;
        base_row = (r + 1) % 4;
    endtask

    // Key put down in row r, reset hits when the debounce count reaches 10.
    task automatic reset_mid_debounce(input int r, input logic [3:0] cols);
        int e;
        logic [15:0] pmask;
        pmask = 16'(cols) << (4 * r);
        e = next_sample(r, cyc);
        while (cyc < e + 10) begin
            pressed = pmask;
            check_cycle((cyc < e) ? scan_row(cyc) : r, 1'b0, 1'b0, exp_code);
            step();
        end
        check_cycle(r, 1'b0, 1'b0, exp_code);
        rst = 1'b1;
        #1;
        exp_code = 4'h0;
        check_cycle(0, 1'b0, 1'b0, exp_code);
        for (int i = 0; i < 3; i++) begin
            step();
            check_cycle(0, 1'b0, 1'b0, exp_code);
        end
        pressed  = 16'h0;
        rst      = 1'b0;
        base_cyc = cyc;
        base_row = 0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        pressed  = 16'h0;
        exp_code = 4'h0;
        rst      = 1'b0;
        #1 rst   = 1'b1;
        #1;
        check_cycle(0, 1'b0, 1'b0, 4'h0);
        step();
        check_cycle(0, 1'b0, 1'b0, 4'h0);
        step();
        rst      = 1'b0;
        base_cyc = cyc;
        base_row = 0;

        $display("[TB] idle scan");
        idle(24);

        $display("[TB] row 2 col 1 held");
        applyStimulus(2, 4'b0010, 0, 40, 0, 6);

        $display("[TB] short press row 0 col 3");
        applyStimulus(0, 4'b1000, 0, 8, 0, 10);

        $display("[TB] row 1 cols 0+2 with release bounce");
        bhi[0] = 3;
        blo[0] = 2;
        applyStimulus(1, 4'b0101, 1, 30, 1, 6);

        $display("[TB] debounce boundary");
        applyStimulus(3, 4'b1000, 2, D - 1, 0, 4);
        applyStimulus(3, 4'b1000, 2, D, 0, 4);

        $display("[TB] reset during press debounce");
        reset_mid_debounce(3, 4'b0001);
        idle(12);

        $display("[TB] random key events");
        for (int k = 0; k < 14; k++) begin
            int nb;
            nb = $urandom_range(0, 2);
            for (int i = 0; i < 3; i++) begin
                bhi[i] = $urandom_range(1, D);
                blo[i] = $urandom_range(1, 5);
            end
            applyStimulus($urandom_range(0, 3), 4'($urandom_range(1, 15)),
                          $urandom_range(0, 9), $urandom_range(0, 45), nb,
                          $urandom_range(0, 6));
        end

`ifdef KEY_SCAN_AUTOREPEAT_EN
        $display("[TB] auto-repeat hold");
        applyStimulus(0, 4'b0001, 0, 600, 0, 4);
`endif

        idle(8);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter DEBOUNCE, default 20, consecutive stable clk cycles required to accept a press or a release.
REQ-002 Parameter SCAN_HOLD, default 2, clk cycles each row is driven before its columns are sampled.
REQ-003 Parameter REPEAT, default 250, auto-repeat period in clk cycles (used only with REQ-026).
REQ-004 clk  input  1  system clock (1 kHz on board).
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 row_out  output  4  active-low keypad row drive; exactly one bit low at any time.
REQ-007 col_in  input  4  active-low keypad column sense; external pull-ups; pressed key pulls its column low.
REQ-008 key_code  output  4  last accepted key = {row_idx[1:0], col_idx[1:0]}.
REQ-009 key_valid  output  1  one-cycle pulse per accepted press.
REQ-010 key_held  output  1  high from acceptance until release is accepted.

Function
REQ-011 The FSM SHALL have states SCAN, PRESS_DEB, HELD, REL_DEB; all outputs registered.
REQ-012 SCAN: row_out SHALL drive row row_idx low; hold counter runs 0..SCAN_HOLD-1; col_in is sampled only when hold count = SCAN_HOLD-1.
REQ-013 SCAN sample with col_in = 4'b1111: row_idx SHALL advance (3 wraps to 0) and hold counter clear on the same edge.
REQ-014 SCAN sample with any col_in bit low: col_idx SHALL latch the lowest-index low bit, row_idx is frozen, state -> PRESS_DEB, debounce counter = 0.
REQ-015 PRESS_DEB: each cycle col_in[col_idx] low increments the debounce counter; a high sample SHALL return to SCAN with row_idx advanced (glitch rejected, no pulse).
REQ-016 When the debounce counter reaches DEBOUNCE, key_code SHALL load {row_idx, col_idx}, key_valid pulse high exactly one cycle, key_held go high, state -> HELD.
REQ-017 Press latency: key_valid high DEBOUNCE cycles after entry to PRESS_DEB.
REQ-018 HELD: row_out frozen; col_in[col_idx] high SHALL enter REL_DEB with counter = 0; other columns ignored (no second key while held).
REQ-019 REL_DEB: col_in[col_idx] low SHALL return to HELD (bounce); DEBOUNCE consecutive high samples SHALL clear key_held, advance row_idx, state -> SCAN.
REQ-020 key_code SHALL hold its value until the next accepted press; it is not cleared on release.
REQ-021 Counters SHALL saturate-compare only; widths sized by $clog2 of the parameter + 1; no wrap inside a state.
REQ-022 DEBOUNCE = 1 SHALL accept on the first stable cycle; SCAN_HOLD = 1 samples in the same cycle the row is driven.

Reset
REQ-023 On rst: state SCAN, row_idx 0, row_out 4'b1110, key_code 4'h0, key_valid 0, key_held 0, all counters 0.
REQ-024 rst asserted mid-debounce or mid-hold SHALL abort with no key_valid pulse; after release scanning restarts at row 0.

Configuration
REQ-025 Macro KEY_SCAN_AUTOREPEAT_EN selects auto-repeat.
REQ-026 Defined: in HELD a repeat counter SHALL pulse key_valid (same key_code) every REPEAT cycles after acceptance; counter clears on entry to REL_DEB and does not run there.
REQ-027 Not defined: exactly one key_valid per press; repeat logic absent; REPEAT ignored.

Verification
REQ-028 Reset then idle col_in = 1111 -> row_out cycles 1110,1101,1011,0111,1110 changing every SCAN_HOLD = 2 cycles; key_valid never high.
REQ-029 Hold key row 2 col 1 (col_in = 1101 while row_out = 1011) for 50 cycles -> one key_valid pulse 20 cycles after PRESS_DEB entry, key_code = 4'h9, key_held high until 20 cycles after release.
REQ-030 Press row 0 col 3 for 10 cycles then release -> no key_valid, scanning resumes at row 1.
REQ-031 Press row 1 cols 0 and 2 together -> key_code = 4'h4; release bounce (3 high, 2 low, then high) -> key_held clears only after 20 consecutive high cycles.
REQ-032 Assert rst at PRESS_DEB count 10 -> outputs at reset values, no pulse; with KEY_SCAN_AUTOREPEAT_EN, 600-cycle hold -> key_valid pulses at acceptance, +250, +500.
